// File: rtl/reset_pkg.sv
// Shared types and elaboration helpers for the cross-domain reset request controller.
package reset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } rst_state_e;

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    endfunction

    function automatic bit params_legal(input int unsigned hold_cycles,
                                        input int unsigned timeout_cycles);
        return (hold_cycles >= 2) && (timeout_cycles > hold_cycles);
    endfunction

endpackage

// File: rtl/sync_level.sv
// N-stage level synchronizer with asynchronous active-low clear; depth clamped to 2.
module sync_level #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], i_d};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[N-1];

endmodule

// File: rtl/reset_req_ctrl.sv
// Drives a held, acknowledged active-low reset request into a remote clock domain,
// with a timeout on both the enter-reset and leave-reset handshake phases.
module reset_req_ctrl
    import reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          POR_ASSERT     = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rst_req,
    input  logic i_ack_async,
    output logic o_rst_n,
    output logic o_busy,
    output logic o_done,
    output logic o_timeout
);

    localparam int unsigned      CNT_W       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam rst_state_e       RESET_STATE = POR_ASSERT ? ST_ASSERT : ST_IDLE;

    if (!params_legal(HOLD_CYCLES, TIMEOUT_CYCLES)) begin : g_bad_params
        $error("reset_req_ctrl: TIMEOUT_CYCLES > HOLD_CYCLES >= 2 is required");
    end

    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_n_q, rst_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             ack_s;

    sync_level #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_ack_async),
        .o_q     (ack_s)
    );

    // Next state, counter and sticky timeout; outputs decoded from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_rst_req) begin
                    state_d   = ST_ASSERT;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_ASSERT: begin
                // Hold time is enforced even when the remote already reports reset.
                if ((cnt_q >= HOLD_LAST) && ack_s) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ST_RELEASE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        rst_n_d = (state_d != ST_ASSERT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // Remote domain stays in reset while this domain is in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            rst_n_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_n_q   <= rst_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_rst_n   = rst_n_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_reset_req_ctrl.sv
// Bench for reset_req_ctrl: two instances (power-on sequence on / off) each with a
// behavioural remote domain that acknowledges NOT o_rst_n after a programmable delay.
module tb_reset_req_ctrl;

    localparam int HOLD   = 16;
    localparam int TMO    = 64;
    localparam int SYNC   = 2;
    localparam int BUDGET = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req   [2] = '{1'b0, 1'b0};
    logic ack   [2] = '{1'b0, 1'b0};
    logic rst_o [2];
    logic busy  [2];
    logic done  [2];
    logic tmo   [2];

    logic [127:0] pipe [2] = '{128'd0, 128'd0};
    int delay = 3;
    int mode  = 0;     // 0: follows o_rst_n, 1: stuck low, 2: sticks high once risen
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reset_req_ctrl #(
        .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC), .POR_ASSERT(1'b1)
    ) dut_por (
        .i_clk(clk), .i_rst_n(rst_n), .i_rst_req(req[0]), .i_ack_async(ack[0]),
        .o_rst_n(rst_o[0]), .o_busy(busy[0]), .o_done(done[0]), .o_timeout(tmo[0])
    );

    reset_req_ctrl #(
        .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC), .POR_ASSERT(1'b0)
    ) dut_idle (
        .i_clk(clk), .i_rst_n(rst_n), .i_rst_req(req[1]), .i_ack_async(ack[1]),
        .o_rst_n(rst_o[1]), .o_busy(busy[1]), .o_done(done[1]), .o_timeout(tmo[1])
    );

    // Remote domain: "in reset" level is NOT o_rst_n seen delay cycles ago.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pipe[i] = {pipe[i][126:0], ~rst_o[i]};
            case (mode)
                1:       ack[i] = 1'b0;
                2:       ack[i] = ack[i] | pipe[i][7'(delay - 1)];
                default: ack[i] = pipe[i][7'(delay - 1)];
            endcase
        end
    end

    // Reference: the acknowledge becomes usable delay+SYNC cycles after o_rst_n changes.
    function automatic int exp_low(input int m, input int d);
        int rise;
        rise = (m == 1) ? TMO + 1 : d + SYNC;
        if (rise > TMO) return TMO;
        return (rise > HOLD) ? rise : HOLD;
    endfunction

    function automatic int exp_rel(input int m, input int d);
        if (m == 1) return 1;
        if (m == 2) return TMO;
        return (d + SYNC > TMO) ? TMO : d + SYNC;
    endfunction

    function automatic logic exp_tmo(input int m, input int d);
        return (m != 0) || (d + SYNC > TMO);
    endfunction

    // Starting at a negedge inside ASSERT: length of low phase, release phase, then done.
    task automatic measure(input int k, output int lo, output int rl, output logic t,
                           output logic bd, output logic da, output logic ba);
        lo = 0;
        rl = 0;
        while (rst_o[k] === 1'b0 && done[k] !== 1'b1 && lo < BUDGET) begin
            lo++;
            @(negedge clk);
        end
        while (done[k] !== 1'b1 && rl < BUDGET) begin
            rl++;
            @(negedge clk);
        end
        t  = tmo[k];
        bd = busy[k];
        @(negedge clk);
        da = done[k];
        ba = busy[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({rst_o[k], busy[k], done[k], tmo[k]} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: got %b, want 0000", k,
                         {rst_o[k], busy[k], done[k], tmo[k]});
            end
        end
    endtask

    task automatic test_por();
        int lo, rl;
        logic t, bd, da, ba;
        delay = 3;
        mode  = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        measure(0, lo, rl, t, bd, da, ba);
        // Remote already acknowledges from reset, so only the hold time limits the pulse.
        vectors++;
        if (lo !== HOLD) begin miscompares++; $display("FAIL por_low_len: got %0d, want %0d", lo, HOLD); end
        vectors++;
        if (rl !== exp_rel(0, 3)) begin miscompares++; $display("FAIL por_rel_len: got %0d, want %0d", rl, exp_rel(0, 3)); end
        vectors++;
        if ({t, bd, da, ba} !== 4'b0100) begin
            miscompares++;
            $display("FAIL por_done_flags {tmo,busy,done+1,busy+1}: got %b, want 0100", {t, bd, da, ba});
        end
        vectors++;
        if ({rst_o[1], busy[1], tmo[1]} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b, want 100", {rst_o[1], busy[1], tmo[1]});
        end
    endtask

    task automatic test_request();
        int lo, rl, nb, nd;
        logic t, bd, da, ba;
        repeat (20) @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        vectors++;
        if ({rst_o[1], busy[1]} !== 2'b01) begin
            miscompares++;
            $display("FAIL req_latency {rst_n,busy}: got %b, want 01", {rst_o[1], busy[1]});
        end
        fork
            measure(1, lo, rl, t, bd, da, ba);
            begin
                repeat (4) @(negedge clk);
                req[1] = 1'b1;
                @(negedge clk);
                req[1] = 1'b0;
            end
        join
        vectors++;
        if (lo !== exp_low(0, 3)) begin miscompares++; $display("FAIL req_low_len: got %0d, want %0d", lo, exp_low(0, 3)); end
        vectors++;
        if (rl !== exp_rel(0, 3)) begin miscompares++; $display("FAIL req_rel_len: got %0d, want %0d", rl, exp_rel(0, 3)); end
        vectors++;
        if ({t, bd, da, ba} !== 4'b0100) begin
            miscompares++;
            $display("FAIL req_done_flags: got %b, want 0100", {t, bd, da, ba});
        end
        nb = 0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy[1] === 1'b1) nb++;
            if (done[1] === 1'b1) nd++;
        end
        vectors++;
        if (nb !== 0 || nd !== 0) begin
            miscompares++;
            $display("FAIL req_not_queued busy/done cycles: got %0d/%0d, want 0/0", nb, nd);
        end
    endtask

    task automatic test_stuck_low();
        int lo, rl;
        logic t, bd, da, ba;
        mode = 1;
        repeat (5) @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        measure(1, lo, rl, t, bd, da, ba);
        vectors++;
        if (lo !== exp_low(1, delay)) begin miscompares++; $display("FAIL stuck0_low_len: got %0d, want %0d", lo, exp_low(1, delay)); end
        vectors++;
        if (rl !== exp_rel(1, delay)) begin miscompares++; $display("FAIL stuck0_rel_len: got %0d, want %0d", rl, exp_rel(1, delay)); end
        vectors++;
        if ({t, da} !== 2'b10) begin miscompares++; $display("FAIL stuck0_timeout {tmo,done+1}: got %b, want 10", {t, da}); end
        mode = 0;
        repeat (10) @(negedge clk);
        vectors++;
        if (tmo[1] !== 1'b1) begin miscompares++; $display("FAIL stuck0_sticky: got %b, want 1", tmo[1]); end
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        vectors++;
        if (tmo[1] !== 1'b0) begin miscompares++; $display("FAIL timeout_clear_on_start: got %b, want 0", tmo[1]); end
        measure(1, lo, rl, t, bd, da, ba);
        vectors++;
        if (lo !== exp_low(0, delay) || t !== 1'b0) begin
            miscompares++;
            $display("FAIL after_timeout_seq low/tmo: got %0d/%b, want %0d/0", lo, t, exp_low(0, delay));
        end
    endtask

    task automatic test_stuck_high();
        int lo, rl;
        logic t, bd, da, ba;
        repeat (10) @(negedge clk);
        mode = 2;
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        measure(1, lo, rl, t, bd, da, ba);
        vectors++;
        if (lo !== exp_low(2, delay)) begin miscompares++; $display("FAIL stuck1_low_len: got %0d, want %0d", lo, exp_low(2, delay)); end
        vectors++;
        if (rl !== exp_rel(2, delay)) begin miscompares++; $display("FAIL stuck1_rel_len: got %0d, want %0d", rl, exp_rel(2, delay)); end
        vectors++;
        if ({t, bd, da, ba} !== 4'b1100) begin miscompares++; $display("FAIL stuck1_flags: got %b, want 1100", {t, bd, da, ba}); end
        mode = 0;
    endtask

    task automatic test_async_reset();
        int lo, rl;
        logic t, bd, da, ba;
        repeat (25) @(negedge clk);
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({rst_o[0], busy[0], done[0], tmo[0]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got %b, want 0000", {rst_o[0], busy[0], done[0], tmo[0]});
        end
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        measure(0, lo, rl, t, bd, da, ba);
        vectors++;
        if (lo !== HOLD) begin miscompares++; $display("FAIL rerun_low_len: got %0d, want %0d", lo, HOLD); end
        vectors++;
        if (rl !== exp_rel(0, delay) || {t, bd, da, ba} !== 4'b0100) begin
            miscompares++;
            $display("FAIL rerun_release rel/flags: got %0d/%b, want %0d/0100", rl, {t, bd, da, ba}, exp_rel(0, delay));
        end
    endtask

    task automatic test_back_to_back();
        int lo, rl, elapsed;
        logic t, bd, da, ba;
        repeat (25) @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        elapsed = 1;
        for (int s = 0; s < 20; s++) begin
            if (elapsed >= 200) req[1] = 1'b0;
            vectors++;
            if (rst_o[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_start seq%0d: got %b, want 0", s, rst_o[1]); end
            measure(1, lo, rl, t, bd, da, ba);
            vectors++;
            if (lo !== exp_low(0, delay) || rl !== exp_rel(0, delay)) begin
                miscompares++;
                $display("FAIL b2b_lengths seq%0d low/rel: got %0d/%0d, want %0d/%0d", s, lo, rl,
                         exp_low(0, delay), exp_rel(0, delay));
            end
            vectors++;
            if ({rst_o[1], ba, da} !== 3'b100) begin
                miscompares++;
                $display("FAIL b2b_idle_gap seq%0d: got %b, want 100", s, {rst_o[1], ba, da});
            end
            if (req[1] === 1'b0) break;
            elapsed += lo + rl + 2;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (busy[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_stop: got %b, want 0", busy[1]); end
    endtask

    task automatic test_random();
        int lo, rl, k;
        logic t, bd, da, ba;
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(25, 40)) @(negedge clk);
            k     = int'($urandom_range(0, 1));
            delay = int'($urandom_range(1, 20));
            mode  = int'($urandom_range(0, 2));
            req[k] = 1'b1;
            @(negedge clk);
            req[k] = 1'b0;
            measure(k, lo, rl, t, bd, da, ba);
            vectors++;
            if (lo !== exp_low(mode, delay) || rl !== exp_rel(mode, delay)) begin
                miscompares++;
                $display("FAIL rand%0d dut%0d d=%0d m=%0d low/rel: got %0d/%0d, want %0d/%0d", n, k,
                         delay, mode, lo, rl, exp_low(mode, delay), exp_rel(mode, delay));
            end
            vectors++;
            if ({t, bd, da, ba} !== {exp_tmo(mode, delay), 3'b100}) begin
                miscompares++;
                $display("FAIL rand%0d_flags: got %b, want %b", n, {t, bd, da, ba},
                         {exp_tmo(mode, delay), 3'b100});
            end
            mode = 0;
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (20) @(negedge clk);
        test_reset();
        test_por();
        test_request();
        test_stuck_low();
        test_stuck_high();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
